// File: rtl/switch_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// switch_arbiter_ctrl
//
// Shared debounce and trigger controller for up to N active-low panel
// switches. Each switch is synchronised and its press is latched into a
// pending request. Requests are served one at a time in round-robin order.
// Each served request produces a PULSE_CYC-cycle one-hot trigger, followed by
// a single shared LOCKOUT_CYC-cycle lockout that acts as the jitter filter.
//
// Ports
//   clk      in   system clock (50 MHz fabric clock)
//   rst      in   asynchronous reset, active low
//   sw_n     in   [N]   raw switch levels, low = pressed, asynchronous to clk
//   enable   in   high = new presses may be latched
//   trig     out  [N]   one-hot trigger, high PULSE_CYC cycles per served press
//   trig_id  out  [IDW] index of the switch currently or last served
//   busy     out  high while the FSM is in PULSE or LOCK
//   pending  out  [N]   latched, not-yet-served press requests
// -----------------------------------------------------------------------------
module switch_arbiter_ctrl #(
  parameter int N           = 4,
  parameter int IDW         = 2,
  parameter int CNT_W       = 25,
  parameter int PULSE_CYC   = 500,
  parameter int LOCKOUT_CYC = 25000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sw_n,
  input  logic           enable,
  output logic [N-1:0]   trig,
  output logic [IDW-1:0] trig_id,
  output logic           busy,
  output logic [N-1:0]   pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    LOCK  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYC - 1);
  // Pointer starts at the highest index so switch 0 wins the first search.
  localparam logic [IDW-1:0]   LAST_INIT  = IDW'(N - 1);

  state_t           state, state_nxt;
  logic [N-1:0]     sync1, s;
  logic [N-1:0]     armed, armed_nxt;
  logic [N-1:0]     pending_nxt;
  logic [N-1:0]     press;
  logic [N-1:0]     own_mask;
  logic [N-1:0]     grant_mask;
  logic [N-1:0]     trig_nxt;
  logic [IDW-1:0]   trig_id_nxt;
  logic [IDW-1:0]   last, last_nxt;
  logic             busy_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  int               idx;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Resets to all ones (= released) so a reset never
  // looks like a press.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours (sync1 -> s here).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      s     <= '1;
    end else begin
      sync1 <= sw_n;
      s     <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Press latch. A switch is armed only after it has been seen released, and
  // re-arming is blocked while that same switch owns the pulse/lockout, so
  // contact bounce during its own sequence cannot queue a second press.
  // ---------------------------------------------------------------------------
  assign press     = armed & ~s & {N{enable}};
  assign own_mask  = busy ? (N'(1) << trig_id) : '0;
  assign armed_nxt = (armed & ~press) | (s & ~own_mask);

  // ---------------------------------------------------------------------------
  // Round-robin search: first pending bit at last+1, last+2, ... mod N.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!grant_vld && ((pending & (N'(1) << idx)) != '0)) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and registered-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    trig_nxt    = trig;
    trig_id_nxt = trig_id;
    last_nxt    = last;
    busy_nxt    = busy;
    grant_mask  = '0;

    unique case (state)
      IDLE: begin
        if (grant_vld) begin
          grant_mask  = N'(1) << grant_idx;
          trig_nxt    = grant_mask;
          trig_id_nxt = grant_idx;
          last_nxt    = grant_idx;
          count_nxt   = '0;
          busy_nxt    = 1'b1;
          state_nxt   = PULSE;
        end
      end

      PULSE: begin
        if (count == PULSE_LAST) begin
          trig_nxt  = '0;
          count_nxt = '0;
          state_nxt = LOCK;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end

      LOCK: begin
        if (count == LOCK_LAST) begin
          count_nxt = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end

      default: begin
        trig_nxt  = '0;
        count_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // A new press on the granted bit in the grant cycle is kept (set wins).
  assign pending_nxt = (pending & ~grant_mask) | press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      trig    <= '0;
      trig_id <= '0;
      busy    <= 1'b0;
      pending <= '0;
      armed   <= '1;
      last    <= LAST_INIT;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      trig    <= trig_nxt;
      trig_id <= trig_id_nxt;
      busy    <= busy_nxt;
      pending <= pending_nxt;
      armed   <= armed_nxt;
      last    <= last_nxt;
    end
  end

endmodule

// File: tb/tb_switch_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_switch_arbiter_ctrl
//
// Scoreboard bench for switch_arbiter_ctrl (N=4, PULSE_CYC=4, LOCKOUT_CYC=20).
// The stimulus process pushes each expected trigger (one-hot value, index and
// optional exact gap from the previous pulse) into a queue before pressing.
// A monitor process pops an entry at each rising trigger, and it checks the
// pulse width at the falling edge. The stimulus process also makes a few
// cycle-exact checks of pending/busy. Inputs are driven and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_switch_arbiter_ctrl;

  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int PULSE = 4;
  localparam int GAP   = 21;

  typedef struct {
    logic [N-1:0] trig;
    int           id;
    int           gap;   // 0 = do not check the gap
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   sw_n;
  logic           enable;
  logic [N-1:0]   trig;
  logic [IDW-1:0] trig_id;
  logic           busy;
  logic [N-1:0]   pending;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  switch_arbiter_ctrl #(
    .N          (N),
    .IDW        (IDW),
    .CNT_W      (8),
    .PULSE_CYC  (PULSE),
    .LOCKOUT_CYC(20)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_n   (sw_n),
    .enable (enable),
    .trig   (trig),
    .trig_id(trig_id),
    .busy   (busy),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_trig(input int id, input int gap);
    exp_t e;
    e.trig = N'(1) << id;
    e.id   = id;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard at every rising trigger.
  // ---------------------------------------------------------------------------
  initial begin
    logic [N-1:0] prev_trig;
    int           width;
    int           gap_cnt;
    bit           have_gap;
    exp_t         e;
    prev_trig = '0;
    width     = 0;
    gap_cnt   = 0;
    have_gap  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_trig = '0;
        width     = 0;
        have_gap  = 1'b0;
      end else begin
        if (trig != '0 && prev_trig == '0) begin
          if (exp_q.size() == 0) begin
            check("trig_unexpected", 32'(trig), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("trig_value", 32'(trig), 32'(e.trig));
            check("trig_id", 32'(trig_id), 32'(e.id));
            check("busy_with_trig", 32'(busy), 32'(1));
            if (e.gap != 0 && have_gap)
              check("trig_gap", 32'(gap_cnt), 32'(e.gap));
          end
          width = 1;
        end else if (trig != '0) begin
          check("trig_stable", 32'(trig), 32'(prev_trig));
          width++;
        end else if (prev_trig != '0) begin
          check("pulse_width", 32'(width), 32'(PULSE));
          gap_cnt  = 1;
          have_gap = 1'b1;
        end else begin
          gap_cnt++;
        end
        prev_trig = trig;
      end
    end
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Stimulus.
  // ---------------------------------------------------------------------------
  initial begin
    rst    = 1'b0;
    sw_n   = '1;
    enable = 1'b1;
    cyc(2);
    check("rst_trig", 32'(trig), 32'(0));
    check("rst_trig_id", 32'(trig_id), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_pending", 32'(pending), 32'(0));
    rst = 1'b1;
    cyc(3);

    // ---- Single press on switch 1, held 100 cycles --------------------------
    expect_trig(1, 0);
    sw_n[1] = 1'b0;
    cyc(2);
    check("single_pending_e2", 32'(pending), 32'(0));
    cyc(1);
    check("single_pending_e3", 32'(pending), 32'h2);
    check("single_trig_e3", 32'(trig), 32'(0));
    cyc(1);
    check("single_trig_e4", 32'(trig), 32'h2);
    check("single_busy_e4", 32'(busy), 32'(1));
    check("single_pending_e4", 32'(pending), 32'(0));
    cyc(23);
    check("single_busy_e27", 32'(busy), 32'(1));
    cyc(1);
    check("single_busy_e28", 32'(busy), 32'(0));
    cyc(72);
    check("held_pending", 32'(pending), 32'(0));
    check("trig_id_hold", 32'(trig_id), 32'(1));
    sw_n = '1;
    cyc(5);
    expect_trig(1, 0);
    sw_n[1] = 1'b0;
    cyc(40);
    sw_n = '1;
    cyc(5);

    // ---- Simultaneous press of all switches after reset ---------------------
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(2);
    expect_trig(0, 0);
    expect_trig(1, GAP);
    expect_trig(2, GAP);
    expect_trig(3, GAP);
    sw_n = 4'b0000;
    cyc(3);
    check("simul_pending_1111", 32'(pending), 32'hF);
    cyc(1);
    check("simul_pending_1110", 32'(pending), 32'hE);
    cyc(1);
    sw_n = '1;
    cyc(24);
    check("simul_pending_1100", 32'(pending), 32'hC);
    cyc(25);
    check("simul_pending_1000", 32'(pending), 32'h8);
    cyc(25);
    check("simul_pending_0000", 32'(pending), 32'h0);
    cyc(30);

    // ---- Round-robin: serve 2, then 0 and 3 together -> 3 before 0 ----------
    expect_trig(2, 0);
    sw_n[2] = 1'b0;
    cyc(3);
    sw_n = '1;
    cyc(35);
    expect_trig(3, 0);
    expect_trig(0, GAP);
    sw_n = 4'b0110;
    cyc(3);
    check("rr_pending", 32'(pending), 32'h9);
    cyc(1);
    sw_n = '1;
    cyc(60);

    // ---- Bounce on switch 0, then held low -> exactly one trigger -----------
    expect_trig(0, 0);
    for (int i = 0; i < 8; i++) begin
      sw_n[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc(2);
    end
    sw_n[0] = 1'b0;
    cyc(60);
    check("bounce_pending", 32'(pending), 32'(0));
    sw_n = '1;
    cyc(5);

    // ---- enable low blocks latching -----------------------------------------
    enable  = 1'b0;
    sw_n[2] = 1'b0;
    cyc(5);
    check("disabled_pending", 32'(pending), 32'(0));
    cyc(30);
    check("disabled_busy", 32'(busy), 32'(0));
    sw_n = '1;
    cyc(5);
    // A press latched just before enable drops is still served.
    enable = 1'b1;
    expect_trig(2, 0);
    sw_n[2] = 1'b0;
    cyc(3);
    enable = 1'b0;
    check("late_disable_pending", 32'(pending), 32'h4);
    cyc(40);
    sw_n   = '1;
    enable = 1'b1;
    cyc(5);

    // ---- Reset in the middle of a pulse -------------------------------------
    expect_trig(0, 0);
    sw_n[0] = 1'b0;
    cyc(4);
    check("pre_reset_trig", 32'(trig), 32'h1);
    cyc(1);
    rst = 1'b0;
    #1;
    check("midrst_trig", 32'(trig), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_pending", 32'(pending), 32'(0));
    cyc(2);
    sw_n = '1;
    rst  = 1'b1;
    cyc(3);
    check("post_rst_busy", 32'(busy), 32'(0));
    expect_trig(1, 0);
    sw_n[1] = 1'b0;
    cyc(3);
    check("post_rst_trig_e3", 32'(trig), 32'(0));
    cyc(1);
    check("post_rst_trig_e4", 32'(trig), 32'h2);
    cyc(30);
    sw_n = '1;
    cyc(5);

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
